// File: rtl/spi_regmap_pkg.sv
// Shared types and constants for the SPI register map: FSM states,
// R/W bit encoding and the SPI-mode to sample-edge mapping.
package spi_regmap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // Leading edge leaves the CPOL idle level; CPHA picks leading or trailing.
  // Net effect: modes 0 and 3 sample on rising SCK, modes 1 and 2 on falling.
  function automatic logic sample_edge(input logic cpol, input logic cpha);
    return (cpol ^ cpha) ? EDGE_FALL : EDGE_RISE;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end: 2-flop synchronisers on sck, cs_n and sdi, plus
// SCK edge detection producing 1-clk sample/shift pulses. cs_n and sdi are
// delayed by one extra flop so they line up with the pulses (3 clk from pin).
module spi_edge_sync
  import spi_regmap_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sck_i,
  input  logic cs_n_i,
  input  logic sdi_i,
  output logic cs_n_o,
  output logic sdi_o,
  output logic sample_pulse_o,
  output logic shift_pulse_o
);

  localparam logic SAMPLE_EDGE = sample_edge(CPOL, CPHA);

  logic [1:0] sck_sync_q;
  logic [1:0] cs_sync_q;
  logic [1:0] sdi_sync_q;
  logic       sck_prev_q;
  logic       cs_q;
  logic       sdi_q;
  logic       sample_q;
  logic       shift_q;
  logic       sck_rise;
  logic       sck_fall;

  assign sck_rise = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall = ~sck_sync_q[1] & sck_prev_q;

  // Synchronise the pins and register the edge pulses.
  // cs_n resets to "selected" so a frame already in progress during reset is
  // never mistaken for a fresh cs_n falling edge; sck resets to its idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q <= {2{CPOL}};
      sck_prev_q <= CPOL;
      cs_sync_q  <= 2'b00;
      cs_q       <= 1'b0;
      sdi_sync_q <= 2'b00;
      sdi_q      <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[0], sck_i};
      sck_prev_q <= sck_sync_q[1];
      cs_sync_q  <= {cs_sync_q[0], cs_n_i};
      cs_q       <= cs_sync_q[1];
      sdi_sync_q <= {sdi_sync_q[0], sdi_i};
      sdi_q      <= sdi_sync_q[1];
      sample_q   <= (SAMPLE_EDGE == EDGE_RISE) ? sck_rise : sck_fall;
      shift_q    <= (SAMPLE_EDGE == EDGE_RISE) ? sck_fall : sck_rise;
    end
  end

  assign cs_n_o         = cs_q;
  assign sdi_o          = sdi_q;
  assign sample_pulse_o = sample_q;
  assign shift_pulse_o  = shift_q;

endmodule

// File: rtl/spi_regmap_burst.sv
// SPI-slave register map: NUM_CFG R/W config registers followed by NUM_STAT
// read-only status registers. Frame = R/W bit, address, data word(s), MSB first.
// Define SPI_REGMAP_BURST_EN for multi-word bursts with address auto-increment;
// without it the slave handles one data word per frame and then holds.
module spi_regmap_burst
  import spi_regmap_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CFG    = 12,
  parameter int                    NUM_STAT   = 4,
  parameter bit                    CPOL       = 1'b0,
  parameter bit                    CPHA       = 1'b0,
  parameter logic [DATA_WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sck,
  input  logic                           cs_n,
  input  logic                           sdi,
  output logic                           sdo,
  output logic                           sdo_oe,
  output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_o,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] status_i,
  output logic [ADDR_WIDTH-1:0]          acc_addr,
  output logic                           wr_stb,
  output logic                           rd_stb,
  output logic                           frame_err
);

  localparam int AW       = ADDR_WIDTH;
  localparam int DW       = DATA_WIDTH;
  localparam int MAX_BITS = (AW + 1 > DW) ? AW + 1 : DW;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(AW);
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
`ifdef SPI_REGMAP_BURST_EN
  localparam logic [AW-1:0]    ADDR_ONE      = AW'(1);
`endif

  logic cs_s, sdi_s, sample_p, shift_p;

  spi_edge_sync #(.CPOL(CPOL), .CPHA(CPHA)) u_edge_sync (
    .clk            (clk),
    .rst            (rst),
    .sck_i          (sck),
    .cs_n_i         (cs_n),
    .sdi_i          (sdi),
    .cs_n_o         (cs_s),
    .sdi_o          (sdi_s),
    .sample_pulse_o (sample_p),
    .shift_pulse_o  (shift_p)
  );

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             rw_q;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    hdr_q;
  logic [DW-2:0]    rx_q;
  logic [DW-1:0]    tx_q;
  logic [DW-1:0]    cfg_q [NUM_CFG];
  logic             cs_prev_q;
  logic             wr_stb_q, rd_stb_q, frame_err_q, sdo_oe_q;
`ifdef SPI_REGMAP_BURST_EN
  logic             inc_pend_q;
`endif

  logic [AW:0]      hdr_full;
  logic [DW-1:0]    rx_full;
  logic [AW-1:0]    fetch_addr;
  logic [DW-1:0]    rd_data;

  assign hdr_full = {hdr_q, sdi_s};
  assign rx_full  = {rx_q, sdi_s};

  // Read-word fetch: address just completed in the header, or the next burst address.
  always_comb begin
`ifdef SPI_REGMAP_BURST_EN
    fetch_addr = (state_q == ADDR) ? hdr_full[AW-1:0] : addr_q + ADDR_ONE;
`else
    fetch_addr = hdr_full[AW-1:0];
`endif
    rd_data = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (int'(fetch_addr) == i) rd_data = cfg_q[i];
    for (int i = 0; i < NUM_STAT; i++)
      if (int'(fetch_addr) == NUM_CFG + i) rd_data = status_i[i*DW +: DW];
  end

  // Frame FSM with shift registers, register file and strobes.
  // tx_q skips the first shift edge of each word (bit_cnt_q == 0) so the
  // freshly loaded MSB is presented for the master's first sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rw_q        <= RW_WRITE;
      addr_q      <= '0;
      hdr_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cs_prev_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      sdo_oe_q    <= 1'b0;
`ifdef SPI_REGMAP_BURST_EN
      inc_pend_q  <= 1'b0;
`endif
      for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RESET;
    end else begin
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      frame_err_q <= 1'b0;
      cs_prev_q   <= cs_s;
      sdo_oe_q    <= ~cs_s & (state_q != IDLE);
      if (cs_s) begin
        if (state_q == DATA && bit_cnt_q != '0) frame_err_q <= 1'b1;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_prev_q) begin
              state_q   <= ADDR;
              bit_cnt_q <= '0;
              hdr_q     <= '0;
              tx_q      <= '0;
`ifdef SPI_REGMAP_BURST_EN
              inc_pend_q <= 1'b0;
`endif
            end else begin
              state_q <= HOLD;
            end
          end
          ADDR: begin
            if (sample_p) begin
              if (bit_cnt_q == LAST_ADDR_BIT) begin
                rw_q      <= hdr_full[AW];
                addr_q    <= hdr_full[AW-1:0];
                bit_cnt_q <= '0;
                state_q   <= DATA;
                if (hdr_full[AW] == RW_READ) begin
                  tx_q     <= rd_data;
                  rd_stb_q <= 1'b1;
                end
              end else begin
                hdr_q     <= hdr_full[AW-1:0];
                bit_cnt_q <= bit_cnt_q + CNT_ONE;
              end
            end
          end
          DATA: begin
            if (sample_p) begin
              rx_q <= rx_full[DW-2:0];
`ifdef SPI_REGMAP_BURST_EN
              if (inc_pend_q) begin
                addr_q     <= addr_q + ADDR_ONE;
                inc_pend_q <= 1'b0;
              end
`endif
              if (bit_cnt_q == LAST_DATA_BIT) begin
                bit_cnt_q <= '0;
                if (rw_q == RW_WRITE) begin
                  wr_stb_q <= 1'b1;
                  for (int i = 0; i < NUM_CFG; i++)
                    if (int'(addr_q) == i) cfg_q[i] <= rx_full;
                end
`ifdef SPI_REGMAP_BURST_EN
                if (rw_q == RW_READ) begin
                  addr_q   <= addr_q + ADDR_ONE;
                  tx_q     <= rd_data;
                  rd_stb_q <= 1'b1;
                end else begin
                  inc_pend_q <= 1'b1;
                end
`else
                state_q <= HOLD;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + CNT_ONE;
              end
            end else if (shift_p && bit_cnt_q != '0) begin
              tx_q <= {tx_q[DW-2:0], 1'b0};
            end
          end
          HOLD: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
    assign cfg_o[gi*DW +: DW] = cfg_q[gi];
  end

  assign sdo       = (state_q == DATA) & tx_q[DW-1];
  assign sdo_oe    = sdo_oe_q;
  assign acc_addr  = addr_q;
  assign wr_stb    = wr_stb_q;
  assign rd_stb    = rd_stb_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regmap_burst.sv
// Testbench for spi_regmap_burst: four instances, one per SPI mode (index =
// CPOL*2 + CPHA), driven by a bit-banged SPI master and checked against a
// per-instance register-file model. Honours SPI_REGMAP_BURST_EN.
module tb_spi_regmap_burst;

`ifdef SPI_REGMAP_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int NC = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  sck_r = 4'b1100;
  logic [3:0]  cs_r = 4'hF;
  logic        sdi_r = 1'b0;
  logic [31:0] status_r = 32'hFFFF_0000;

  logic [3:0]  sdo_w, oe_w, wr_w, rd_w, fe_w;
  logic [95:0] cfg_w [4];
  logic [6:0]  acc_w [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    spi_regmap_burst #(
      .ADDR_WIDTH(7), .DATA_WIDTH(8), .NUM_CFG(12), .NUM_STAT(4),
      .CPOL((gi / 2) == 1), .CPHA((gi % 2) == 1), .CFG_RESET(8'h00)
    ) u_dut (
      .clk(clk), .rst(rst), .sck(sck_r[gi]), .cs_n(cs_r[gi]), .sdi(sdi_r),
      .sdo(sdo_w[gi]), .sdo_oe(oe_w[gi]), .cfg_o(cfg_w[gi]),
      .status_i(status_r), .acc_addr(acc_w[gi]), .wr_stb(wr_w[gi]),
      .rd_stb(rd_w[gi]), .frame_err(fe_w[gi])
    );
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         fe_cnt  = 0;
  int         wr_addr_q[$];
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  logic [7:0] cfg_m [4][NC];

  // Strobe monitor (instance 0 write addresses, frame errors on all).
  always @(negedge clk) begin
    if (wr_w[0]) wr_addr_q.push_back(int'(acc_w[0]));
    fe_cnt += $countones(fe_w);
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] exp_word(input int m, input int a);
    if (a < NC) return cfg_m[m][a];
    if (a < NC + 4) return status_r[(a - NC)*8 +: 8];
    return 8'h00;
  endfunction

  task automatic check_cfg(input int m, input string tag);
    logic [95:0] e;
    for (int i = 0; i < NC; i++) e[i*8 +: 8] = cfg_m[m][i];
    check_eq($sformatf("%s m%0d", tag, m), cfg_w[m], e);
  endtask

  // Bit-banged master: header then nbits data bits (negative = cut header short).
  task automatic xfer(input int m, input bit rd, input int addr, input int nbits, input int rst_at);
    logic [7:0] hdr;
    logic [7:0] cur;
    logic       bitv;
    logic       cpol, cpha;
    int         total;
    hdr   = {rd, 7'(addr)};
    cpol  = (m / 2) == 1;
    cpha  = (m % 2) == 1;
    total = 8 + nbits;
    cur   = 8'h00;
    rq.delete();
    cs_r[m] = 1'b0;
    wait_clk(5);
    for (int b = 0; b < total; b++) begin
      if (b < 8) bitv = hdr[7-b];
      else begin
        logic [7:0] w;
        w = wq[(b-8)/8];
        bitv = w[7-((b-8)%8)];
      end
      if (b == rst_at) begin
        rst = 1'b1; wait_clk(2); rst = 1'b0;
      end
      if (!cpha) begin
        sdi_r = bitv; wait_clk(5);
      end else begin
        sck_r[m] = ~cpol; sdi_r = bitv; wait_clk(5);
      end
      if (b < 8) check_eq($sformatf("sdo_hdr m%0d b%0d", m, b), sdo_w[m], 1'b0);
      else cur = {cur[6:0], sdo_w[m]};
      if (b == 8 && rst_at < 0) check_eq($sformatf("sdo_oe m%0d", m), oe_w[m], 1'b1);
      if (!cpha) begin
        sck_r[m] = ~cpol; wait_clk(5); sck_r[m] = cpol;
      end else begin
        sck_r[m] = cpol; wait_clk(5);
      end
      if (b >= 8 && (b - 8) % 8 == 7) rq.push_back(cur);
    end
    wait_clk(5);
    cs_r[m] = 1'b1;
    sdi_r   = 1'b0;
    wait_clk(12);
  endtask

  task automatic do_write(input int m, input int a, input int n);
    int ad;
    xfer(m, 1'b0, a, n*8, -1);
    for (int k = 0; k < n; k++) begin
      ad = (a + k) % 128;
      if ((BURST || k == 0) && ad < NC) cfg_m[m][ad] = wq[k];
    end
    $display("[TB] write m%0d addr %0d words %0d", m, a, n);
  endtask

  task automatic do_read(input int m, input int a, input int n);
    logic [7:0] e;
    wq.delete();
    for (int k = 0; k < n; k++) wq.push_back(8'h00);
    xfer(m, 1'b1, a, n*8, -1);
    for (int k = 0; k < n; k++) begin
      e = (BURST || k == 0) ? exp_word(m, (a + k) % 128) : 8'h00;
      check_eq($sformatf("rd m%0d a%0d w%0d", m, a, k), rq[k], e);
    end
    $display("[TB] read  m%0d addr %0d words %0d", m, a, n);
  endtask

  initial begin
    int fe0;
    int nwr;
    logic [31:0] packed_addr;
    for (int m = 0; m < 4; m++) for (int i = 0; i < NC; i++) cfg_m[m][i] = 8'h00;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(10);

    // Reset state
    check_eq("rst sdo_oe", oe_w[0], 1'b0);
    check_eq("rst sdo", sdo_w[0], 1'b0);
    check_eq("rst wr_stb", wr_w[0], 1'b0);
    check_eq("rst rd_stb", rd_w[0], 1'b0);
    check_eq("rst frame_err", fe_w, 4'h0);
    check_eq("rst acc_addr", acc_w[0], 7'd0);
    check_cfg(0, "rst cfg");
    do_read(0, 0, 1);

    // Single write/read, wr_stb address
    wr_addr_q.delete();
    wq = '{8'hA5};
    do_write(0, 3, 1);
    check_eq("wr_stb count a3", wr_addr_q.size(), 1);
    check_eq("wr_stb addr a3", (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1, 3);
    do_read(0, 3, 1);

    // Status, write to status, out of range
    for (int a = 12; a < 16; a++) do_read(0, a, 1);
    wq = '{8'h55};
    do_write(0, 13, 1);
    do_read(0, 13, 1);
    do_read(0, 40, 1);
    check_cfg(0, "after status wr");

    // Burst write and read
    wr_addr_q.delete();
    wq = '{8'h11, 8'h22, 8'h33};
    do_write(0, 10, 3);
    packed_addr = 0;
    foreach (wr_addr_q[i]) packed_addr = (packed_addr << 8) | 32'(wr_addr_q[i]);
    check_eq("burst wr addrs", packed_addr, BURST ? 32'h000A0B0C : 32'h0000000A);
    check_cfg(0, "burst cfg");
    do_read(0, 10, 3);

    // Mode sweep
    for (int m = 0; m < 4; m++) begin
      wq = '{8'h3C};
      do_write(m, 5, 1);
      do_read(m, 5, 1);
      check_cfg(m, "mode cfg");
    end
    check_eq("no frame_err on boundaries", fe_cnt, 0);

    // Abort mid-word and in the address phase
    fe0 = fe_cnt;
    wq = '{8'hF0};
    xfer(0, 1'b0, 2, 4, -1);
    $display("[TB] abort m0 addr 2 after 4 data bits");
    check_eq("abort frame_err", fe_cnt, fe0 + 1);
    check_cfg(0, "abort cfg");
    xfer(0, 1'b0, 2, -4, -1);
    $display("[TB] abort m0 in address phase");
    check_eq("addr abort frame_err", fe_cnt, fe0 + 1);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      int m, a, n;
      bit rd;
      m = $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      a = ($urandom_range(0, 7) == 0) ? 126 : $urandom_range(0, 18);
      status_r = $urandom;
      if (rd) do_read(m, a, n);
      else begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
        do_write(m, a, n);
        check_cfg(m, "rnd cfg");
      end
    end
    check_eq("rnd frame_err", fe_cnt, fe0 + 1);

    // Reset in the middle of a write frame
    nwr = wr_addr_q.size();
    wq = '{8'h77};
    xfer(0, 1'b0, 1, 8, 10);
    $display("[TB] rst during write m0 addr 1");
    for (int m = 0; m < 4; m++) for (int i = 0; i < NC; i++) cfg_m[m][i] = 8'h00;
    for (int m = 0; m < 4; m++) check_cfg(m, "rst mid-frame cfg");
    check_eq("rst mid-frame no wr_stb", wr_addr_q.size(), nwr);
    wq = '{8'h77};
    do_write(0, 1, 1);
    do_read(0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
